// File: rtl/psum_accumulator.sv
// Ofmap collection stage: accumulates OFMAP_DEPTH psum rows over several input-channel
// passes, then drains saturated rows. Define ACC_RELU_EN to clamp negative outputs to zero.
module psum_accumulator #(
  parameter int BITWIDTH     = 16,
  parameter int PE_X_SIZE    = 3,
  parameter int OFMAP_DEPTH  = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = 3,
  parameter int ACC_WIDTH    = 20
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          start,
  input  logic [CH_W-1:0]               cfg_channels,
  input  logic                          psum_valid,
  output logic                          psum_ready,
  input  logic [BITWIDTH*PE_X_SIZE-1:0] psum_in,
  output logic                          ofmap_valid,
  input  logic                          ofmap_ready,
  output logic [BITWIDTH*PE_X_SIZE-1:0] ofmap_out,
  output logic                          ofmap_last,
  output logic                          busy,
  output logic                          done
);

  // state | meaning
  // IDLE  | waiting for start; no handshakes accepted or offered
  // ACCUM | accepting psum rows, channel 0 overwrites, later channels add
  // DRAIN | presenting saturated buffer rows downstream
  // DONE  | one-cycle done pulse before returning to IDLE

  localparam int RW = (OFMAP_DEPTH > 1) ? $clog2(OFMAP_DEPTH) : 1;
  localparam logic [RW-1:0]   LAST_ROW = RW'(OFMAP_DEPTH - 1);
  localparam logic [CH_W-1:0] MAX_CH   = CH_W'(NUM_CHANNELS);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                      state;
  logic [RW-1:0]               row_cnt;
  logic [RW-1:0]               drain_cnt;
  logic [CH_W-1:0]             ch_cnt;
  logic [CH_W-1:0]             n_ch;
  logic signed [ACC_WIDTH-1:0] acc_buf [OFMAP_DEPTH][PE_X_SIZE];

  logic psum_fire;
  logic ofmap_fire;
  logic last_row;
  logic last_ch;

  assign psum_fire  = psum_ready & psum_valid;
  assign ofmap_fire = ofmap_valid & ofmap_ready;
  assign last_row   = (row_cnt == LAST_ROW);
  assign last_ch    = (ch_cnt == n_ch - CH_W'(1));

  function automatic logic [CH_W-1:0] channel_count(input logic [CH_W-1:0] cfg);
    logic [CH_W-1:0] n;
    if (cfg == '0)
      n = CH_W'(1);
    else if (cfg > MAX_CH)
      n = MAX_CH;
    else
      n = cfg;
    return n;
  endfunction

  function automatic logic [BITWIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    logic [BITWIDTH-1:0] s;
    if (v > SAT_MAX)
      s = SAT_MAX[BITWIDTH-1:0];
    else if (v < SAT_MIN)
      s = SAT_MIN[BITWIDTH-1:0];
    else
      s = v[BITWIDTH-1:0];
`ifdef ACC_RELU_EN
    if (s[BITWIDTH-1])
      s = '0;
`endif
    return s;
  endfunction

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state       <= IDLE;
      row_cnt     <= '0;
      drain_cnt   <= '0;
      ch_cnt      <= '0;
      n_ch        <= '0;
      psum_ready  <= 1'b0;
      ofmap_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_ch       <= channel_count(cfg_channels);
            row_cnt    <= '0;
            ch_cnt     <= '0;
            drain_cnt  <= '0;
            psum_ready <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (psum_fire) begin
            if (last_row) begin
              row_cnt <= '0;
              ch_cnt  <= ch_cnt + CH_W'(1);
              if (last_ch) begin
                drain_cnt   <= '0;
                psum_ready  <= 1'b0;
                ofmap_valid <= 1'b1;
                state       <= DRAIN;
              end
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        DRAIN: begin
          if (ofmap_fire) begin
            if (drain_cnt == LAST_ROW) begin
              ofmap_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              drain_cnt <= drain_cnt + RW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          psum_ready  <= 1'b0;
          ofmap_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Buffer is not reset: the first channel pass overwrites every row of a job.
  always_ff @(posedge clk) begin
    if (psum_fire) begin
      for (int k = 0; k < PE_X_SIZE; k++) begin
        if (ch_cnt == '0)
          acc_buf[row_cnt][k] <= ACC_WIDTH'($signed(psum_in[k*BITWIDTH +: BITWIDTH]));
        else
          acc_buf[row_cnt][k] <= acc_buf[row_cnt][k]
                               + ACC_WIDTH'($signed(psum_in[k*BITWIDTH +: BITWIDTH]));
      end
    end
  end

  // Read straight from the buffer so row 0 already holds the final pass on DRAIN entry.
  always_comb begin
    ofmap_out  = '0;
    ofmap_last = 1'b0;
    if (state == DRAIN) begin
      ofmap_last = (drain_cnt == LAST_ROW);
      for (int k = 0; k < PE_X_SIZE; k++)
        ofmap_out[k*BITWIDTH +: BITWIDTH] = saturate(acc_buf[drain_cnt][k]);
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus randomized jobs
// compared against an arithmetic sum-and-clamp reference model.
module tb_psum_accumulator;

  localparam int BW = 16, PX = 3, DEPTH = 8, NCH = 4, CHW = 3, ACCW = 20;

  logic               clk = 1'b0;
  logic               rstb;
  logic               start;
  logic [CHW-1:0]     cfg_channels;
  logic               psum_valid;
  logic               psum_ready;
  logic [BW*PX-1:0]   psum_in;
  logic               ofmap_valid;
  logic               ofmap_ready;
  logic [BW*PX-1:0]   ofmap_out;
  logic               ofmap_last;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  psum_accumulator #(
    .BITWIDTH(BW), .PE_X_SIZE(PX), .OFMAP_DEPTH(DEPTH),
    .NUM_CHANNELS(NCH), .CH_W(CHW), .ACC_WIDTH(ACCW)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .cfg_channels(cfg_channels),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
    .ofmap_valid(ofmap_valid), .ofmap_ready(ofmap_ready), .ofmap_out(ofmap_out),
    .ofmap_last(ofmap_last), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass = 0;

  int stim [NCH][DEPTH][PX];
  int expv [DEPTH][PX];
  int got  [DEPTH][PX];
  bit got_last [DEPTH];
  int got_rows;
  int unstable;
  bit done_after, done_next, busy_after, valid_next;

  function automatic int eff_channels(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > NCH) return NCH;
    return cfg;
  endfunction

  // Reference: sum every pass in plain integers, then clamp to the output range.
  function automatic void build_expected(input int cfg);
    int n, s;
    n = eff_channels(cfg);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        s = 0;
        for (int c = 0; c < n; c++) s += stim[c][r][k];
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef ACC_RELU_EN
        if (s < 0) s = 0;
`endif
        expv[r][k] = s;
      end
  endfunction

  function automatic void fill_random();
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < DEPTH; r++)
        for (int k = 0; k < PX; k++)
          stim[c][r][k] = int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic drive_row(input int c, input int r);
    for (int k = 0; k < PX; k++) psum_in[k*BW +: BW] = BW'(stim[c][r][k]);
  endtask

  task automatic begin_job(input int cfg);
    @(negedge clk);
    cfg_channels = CHW'(cfg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int passes, input int gap_beat, input int start_beat);
    int beat, guard;
    beat = 0;
    for (int c = 0; c < passes; c++)
      for (int r = 0; r < DEPTH; r++) begin
        if (beat == gap_beat) begin
          psum_valid = 1'b0;
          repeat (3) @(negedge clk);
        end
        drive_row(c, r);
        psum_valid = 1'b1;
        start = (beat == start_beat);
        guard = 0;
        while (!psum_ready && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 20) begin
          n_checks++;
          $display("FAIL feed_timeout ch=%0d row=%0d psum_ready=%0b required 1", c, r, psum_ready);
          psum_valid = 1'b0;
          start = 1'b0;
          return;
        end
        @(negedge clk);
        beat++;
      end
    psum_valid = 1'b0;
    start = 1'b0;
    psum_in = '0;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  task automatic drain(input int mode);
    int guard, cyc;
    bit hold_pending, held_last;
    logic [BW*PX-1:0] held;
    guard = 0; cyc = 0; hold_pending = 0; held_last = 0; held = '0;
    got_rows = 0; unstable = 0;
    for (int r = 0; r < DEPTH; r++) begin
      got_last[r] = 0;
      for (int k = 0; k < PX; k++) got[r][k] = -999999;
    end
    while (got_rows < DEPTH && guard < 200) begin
      if (hold_pending && (ofmap_out !== held || ofmap_last !== held_last || ofmap_valid !== 1'b1))
        unstable++;
      case (mode)
        0: ofmap_ready = 1'b1;
        1: ofmap_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ofmap_ready = 1'($urandom % 2);
      endcase
      if (ofmap_valid && ofmap_ready) begin
        for (int k = 0; k < PX; k++) got[got_rows][k] = int'($signed(ofmap_out[k*BW +: BW]));
        got_last[got_rows] = ofmap_last;
        got_rows++;
        hold_pending = 0;
      end else if (ofmap_valid) begin
        hold_pending = 1;
        held = ofmap_out;
        held_last = ofmap_last;
      end
      @(negedge clk);
      cyc++;
      guard++;
    end
    ofmap_ready = 1'b0;
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL drain_timeout rows=%0d required %0d", got_rows, DEPTH);
    end
    done_after = done;
    busy_after = busy;
    @(negedge clk);
    done_next = done;
    valid_next = ofmap_valid;
  endtask

  task automatic test_reset();
    rstb = 1'b1; start = 1'b0; cfg_channels = '0; psum_valid = 1'b0;
    psum_in = '0; ofmap_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({psum_ready, ofmap_valid, ofmap_last, busy, done} !== 5'b0 || ofmap_out !== '0)
      $display("FAIL reset_outputs got rdy=%0b vld=%0b last=%0b busy=%0b done=%0b out=%h required all 0",
               psum_ready, ofmap_valid, ofmap_last, busy, done, ofmap_out);
    else n_pass++;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({psum_ready, ofmap_valid, busy, done} !== 4'b0)
      $display("FAIL idle_after_reset got rdy=%0b vld=%0b busy=%0b done=%0b required all 0",
               psum_ready, ofmap_valid, busy, done);
    else n_pass++;
  endtask

  task automatic test_single_channel();
    for (int r = 0; r < DEPTH; r++) begin
      stim[0][r][0] = r; stim[0][r][1] = -r; stim[0][r][2] = 100;
    end
    build_expected(1);
    begin_job(1);
    n_checks++;
    if (psum_ready !== 1'b1 || busy !== 1'b1 || ofmap_valid !== 1'b0)
      $display("FAIL single_start got rdy=%0b busy=%0b vld=%0b required 1 1 0", psum_ready, busy, ofmap_valid);
    else n_pass++;
    feed(1, -1, -1);
    n_checks++;
    if (ofmap_valid !== 1'b1 || psum_ready !== 1'b0)
      $display("FAIL single_drain_entry got vld=%0b rdy=%0b required 1 0", ofmap_valid, psum_ready);
    else n_pass++;
    drain(0);
    for (int r = 0; r < DEPTH; r++) begin
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL single_row row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
      n_checks++;
      if (got_last[r] !== (r == DEPTH - 1))
        $display("FAIL single_last row=%0d got=%0b required %0b", r, got_last[r], r == DEPTH - 1);
      else n_pass++;
    end
    n_checks++;
    if (done_after !== 1'b1 || done_next !== 1'b0 || busy_after !== 1'b0)
      $display("FAIL single_done got done=%0b,%0b busy=%0b required 1,0 busy 0", done_after, done_next, busy_after);
    else n_pass++;
  endtask

  task automatic test_four_channel();
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < DEPTH; r++)
        for (int k = 0; k < PX; k++) stim[c][r][k] = 5;
    build_expected(4);
    begin_job(4);
    feed(4, 13, -1);
    drain(0);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL four_ch row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < DEPTH; r++) begin
        stim[c][r][0] = 30000; stim[c][r][1] = -30000; stim[c][r][2] = 30000;
      end
    build_expected(4);
    begin_job(4);
    feed(4, -1, -1);
    drain(0);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL saturation row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
  endtask

  task automatic test_backpressure();
    fill_random();
    build_expected(2);
    begin_job(2);
    feed(2, -1, -1);
    drain(1);
    n_checks++;
    if (unstable !== 0 || got_rows !== DEPTH)
      $display("FAIL backpressure_hold unstable=%0d rows=%0d required 0 and %0d", unstable, got_rows, DEPTH);
    else n_pass++;
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL backpressure row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
    n_checks++;
    if (valid_next !== 1'b0)
      $display("FAIL backpressure_extra_row got vld=%0b required 0", valid_next);
    else n_pass++;
  endtask

  task automatic test_config_clamp();
    fill_random();
    build_expected(0);
    begin_job(0);
    feed(1, -1, -1);
    n_checks++;
    if (ofmap_valid !== 1'b1)
      $display("FAIL clamp_zero_drain got vld=%0b required 1", ofmap_valid);
    else n_pass++;
    drain(0);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL clamp_zero row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
    fill_random();
    build_expected(7);
    begin_job(7);
    feed(4, -1, 10);
    n_checks++;
    if (ofmap_valid !== 1'b1)
      $display("FAIL clamp_seven_drain got vld=%0b required 1", ofmap_valid);
    else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (ofmap_valid !== 1'b1 || busy !== 1'b1 || psum_ready !== 1'b0)
      $display("FAIL start_in_drain got vld=%0b busy=%0b rdy=%0b required 1 1 0", ofmap_valid, busy, psum_ready);
    else n_pass++;
    drain(0);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL clamp_seven row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
  endtask

  task automatic test_reset_mid_accum();
    fill_random();
    begin_job(2);
    for (int b = 0; b < 5; b++) begin
      drive_row(0, b);
      psum_valid = 1'b1;
      @(negedge clk);
    end
    psum_valid = 1'b0;
    #2 rstb = 1'b1;
    #1;
    n_checks++;
    if ({psum_ready, ofmap_valid, ofmap_last, busy, done} !== 5'b0 || ofmap_out !== '0)
      $display("FAIL mid_reset got rdy=%0b vld=%0b last=%0b busy=%0b done=%0b out=%h required all 0",
               psum_ready, ofmap_valid, ofmap_last, busy, done, ofmap_out);
    else n_pass++;
    @(negedge clk);
    rstb = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < DEPTH; r++)
        for (int k = 0; k < PX; k++) stim[c][r][k] = 9;
    build_expected(1);
    begin_job(1);
    feed(1, -1, -1);
    drain(0);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < PX; k++) begin
        n_checks++;
        if (got[r][k] !== expv[r][k])
          $display("FAIL after_reset row=%0d lane=%0d got=%0d required %0d", r, k, got[r][k], expv[r][k]);
        else n_pass++;
      end
  endtask

  task automatic test_random_jobs();
    int cfg;
    for (int j = 0; j < 4; j++) begin
      cfg = int'($urandom_range(0, 7));
      fill_random();
      build_expected(cfg);
      begin_job(cfg);
      feed(eff_channels(cfg), int'($urandom_range(0, 40)), -1);
      drain(2);
      for (int r = 0; r < DEPTH; r++)
        for (int k = 0; k < PX; k++) begin
          n_checks++;
          if (got[r][k] !== expv[r][k])
            $display("FAIL random job=%0d cfg=%0d row=%0d lane=%0d got=%0d required %0d",
                     j, cfg, r, k, got[r][k], expv[r][k]);
          else n_pass++;
        end
      n_checks++;
      if (done_after !== 1'b1 || done_next !== 1'b0)
        $display("FAIL random_done job=%0d got %0b,%0b required 1,0", j, done_after, done_next);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_four_channel();
    test_saturation();
    test_backpressure();
    test_config_clamp();
    test_reset_mid_accum();
    test_random_jobs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
